// File: rtl/yuv444_to_yuv420_if.sv
// Stream dtype codes and the YUV beat bus shared by the 4:4:4 -> 4:2:0 chroma decimator.
// Both the upstream source and the downstream consumer use the same beat layout.
package yuv_dtypes_pkg;
    localparam int unsigned DTYPE_WIDTH = 3;

    localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START = 3'd1;
    localparam logic [DTYPE_WIDTH-1:0] DT_ROW_START   = 3'd2;
    localparam logic [DTYPE_WIDTH-1:0] DT_PIXEL       = 3'd3;
    localparam logic [DTYPE_WIDTH-1:0] DT_ROW_END     = 3'd4;
    localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END   = 3'd5;
endpackage

interface yuv444_to_yuv420_if
    import yuv_dtypes_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 10,
    parameter int unsigned DATA_WIDTH  = 16
);
    logic                   dv;
    logic [DTYPE_WIDTH-1:0] dtype;
    logic [DATA_WIDTH-1:0]  meta_data;
    logic [PIXEL_WIDTH-1:0] y;
    logic [PIXEL_WIDTH-1:0] u;
    logic [PIXEL_WIDTH-1:0] v;
    // Set when u/v carry a freshly computed 2x2 chroma average.
    logic                   cv;

    modport master (output dv, dtype, meta_data, y, u, v, cv);
    modport slave  (input  dv, dtype, meta_data, y, u, v, cv);
endinterface

// File: rtl/yuv444_to_yuv420.sv
// Chroma decimator: averages U/V over each 2x2 block using a half-width line buffer of pair sums,
// while Y, dtype and meta pass through with a fixed two-cycle latency.
module yuv444_to_yuv420
    import yuv_dtypes_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 10,
    parameter int unsigned MAX_COLS    = 1920,
    parameter int unsigned DATA_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    yuv444_to_yuv420_if.slave    in_bus,
    yuv444_to_yuv420_if.master   out_bus
);
    localparam int unsigned CW    = $clog2(MAX_COLS + 1);
    localparam int unsigned DEPTH = MAX_COLS / 2;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW    = PIXEL_WIDTH + 1;
    localparam int unsigned QW    = PIXEL_WIDTH + 2;

    logic                   enable_q;
    logic [CW-1:0]          col;
    logic                   row_odd;
    logic [PIXEL_WIDTH-1:0] u_even;
    logic [PIXEL_WIDTH-1:0] v_even;

    logic [2*SW-1:0]        line_buf [DEPTH];
    logic [2*SW-1:0]        rd_q;

    logic                   s1_dv;
    logic [DTYPE_WIDTH-1:0] s1_dtype;
    logic [DATA_WIDTH-1:0]  s1_meta;
    logic [PIXEL_WIDTH-1:0] s1_y;
    logic [PIXEL_WIDTH-1:0] s1_u;
    logic [PIXEL_WIDTH-1:0] s1_v;
    logic                   s1_cv;

    logic                   frame_start_c;
    logic                   row_start_c;
    logic                   row_end_c;
    logic                   pixel_c;
    logic                   mode_c;
    logic                   col_ok_c;
    logic                   pix_dec_c;
    logic                   wr_en_c;
    logic                   rd_en_c;
    logic                   cv_c;
    logic [AW-1:0]          addr_c;
    logic [SW-1:0]          sum_u_c;
    logic [SW-1:0]          sum_v_c;
    logic [QW-1:0]          tot_u_c;
    logic [QW-1:0]          tot_v_c;

    logic                   enable_n;
    logic [CW-1:0]          col_n;
    logic                   row_odd_n;
    logic [PIXEL_WIDTH-1:0] u_even_n;
    logic [PIXEL_WIDTH-1:0] v_even_n;
    logic [PIXEL_WIDTH-1:0] s1_u_n;
    logic [PIXEL_WIDTH-1:0] s1_v_n;

    // Beat decode; a FRAME_START beat already runs in the mode it latches.
    always_comb begin
        frame_start_c = in_bus.dv && (in_bus.dtype == DT_FRAME_START);
        row_start_c   = in_bus.dv && (in_bus.dtype == DT_ROW_START);
        row_end_c     = in_bus.dv && (in_bus.dtype == DT_ROW_END);
        pixel_c       = in_bus.dv && (in_bus.dtype == DT_PIXEL);
        mode_c        = frame_start_c ? enable : enable_q;
        col_ok_c      = col < CW'(MAX_COLS);
        pix_dec_c     = pixel_c && mode_c && col_ok_c;
        wr_en_c       = pix_dec_c &&  col[0] && !row_odd;
        rd_en_c       = pix_dec_c && !col[0] &&  row_odd;
        cv_c          = pix_dec_c &&  col[0] &&  row_odd;
        addr_c        = AW'(col >> 1);
        sum_u_c       = SW'(u_even) + SW'(in_bus.u);
        sum_v_c       = SW'(v_even) + SW'(in_bus.v);
        tot_u_c       = QW'(rd_q[2*SW-1:SW]) + QW'(sum_u_c) + QW'(2);
        tot_v_c       = QW'(rd_q[SW-1:0])    + QW'(sum_v_c) + QW'(2);
    end

    // Next-state for counters, even-column chroma and stage-1 chroma.
    always_comb begin
        enable_n  = enable_q;
        col_n     = col;
        row_odd_n = row_odd;
        u_even_n  = u_even;
        v_even_n  = v_even;
        s1_u_n    = s1_u;
        s1_v_n    = s1_v;

        if (frame_start_c) begin
            enable_n  = enable;
            col_n     = '0;
            row_odd_n = 1'b0;
        end
        if (row_start_c) begin
            col_n = '0;
        end
        if (row_end_c) begin
            row_odd_n = !row_odd;
        end
        if (pixel_c && col_ok_c) begin
            col_n = col + CW'(1);
        end
        if (pix_dec_c && !col[0]) begin
            u_even_n = in_bus.u;
            v_even_n = in_bus.v;
        end

        if (!mode_c) begin
            s1_u_n = in_bus.u;
            s1_v_n = in_bus.v;
        end else if (cv_c) begin
            s1_u_n = PIXEL_WIDTH'(tot_u_c >> 2);
            s1_v_n = PIXEL_WIDTH'(tot_v_c >> 2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q          <= 1'b0;
            col               <= '0;
            row_odd           <= 1'b0;
            u_even            <= '0;
            v_even            <= '0;
            s1_dv             <= 1'b0;
            s1_dtype          <= '0;
            s1_meta           <= '0;
            s1_y              <= '0;
            s1_u              <= '0;
            s1_v              <= '0;
            s1_cv             <= 1'b0;
            out_bus.dv        <= 1'b0;
            out_bus.dtype     <= '0;
            out_bus.meta_data <= '0;
            out_bus.y         <= '0;
            out_bus.u         <= '0;
            out_bus.v         <= '0;
            out_bus.cv        <= 1'b0;
        end else begin
            enable_q          <= enable_n;
            col               <= col_n;
            row_odd           <= row_odd_n;
            u_even            <= u_even_n;
            v_even            <= v_even_n;
            s1_dv             <= in_bus.dv;
            s1_dtype          <= in_bus.dtype;
            s1_meta           <= in_bus.meta_data;
            s1_y              <= in_bus.y;
            s1_u              <= s1_u_n;
            s1_v              <= s1_v_n;
            s1_cv             <= cv_c;
            out_bus.dv        <= s1_dv;
            out_bus.dtype     <= s1_dtype;
            out_bus.meta_data <= s1_meta;
            out_bus.y         <= s1_y;
            out_bus.u         <= s1_u;
            out_bus.v         <= s1_v;
            out_bus.cv        <= s1_cv;
        end
    end

    // Line buffer of even-row pair sums {U, V}; read data held until the next even-column read.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            line_buf[addr_c] <= {sum_u_c, sum_v_c};
        end
        if (rd_en_c) begin
            rd_q <= line_buf[addr_c];
        end
    end
endmodule

// File: tb/tb_yuv444_to_yuv420.sv
// Directed bench for yuv444_to_yuv420: a frame-level reference (2x2 averages from stored pixels)
// predicts every output beat; literal expectations pin the reference on the key frames.
module tb_yuv444_to_yuv420;
    import yuv_dtypes_pkg::*;

    localparam int unsigned PW   = 10;
    localparam int unsigned DW   = 16;
    localparam int unsigned MAXC = 6;

    typedef struct {
        int              cyc;
        logic [2:0]      dtype;
        logic [DW-1:0]   meta;
        logic [PW-1:0]   y;
        logic [PW-1:0]   u;
        logic [PW-1:0]   v;
        logic            cv;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   gap = 0;
    int   meta_cnt = 0;

    exp_t exp_q[$];
    int   dut_cv_u[$];
    int   dut_cv_v[$];
    int   mdl_cv_u[$];
    int   mdl_cv_v[$];

    // Reference state: mode, position and the two most recent rows of chroma.
    bit   m_mode = 1'b0;
    int   m_row = 0;
    int   m_col = 0;
    int   last_u = 0;
    int   last_v = 0;
    int   fu[2][32];
    int   fv[2][32];
    int   pu[8][16];
    int   pv[8][16];

    yuv444_to_yuv420_if #(.PIXEL_WIDTH(PW), .DATA_WIDTH(DW)) in_if();
    yuv444_to_yuv420_if #(.PIXEL_WIDTH(PW), .DATA_WIDTH(DW)) out_if();

    yuv444_to_yuv420 #(.PIXEL_WIDTH(PW), .MAX_COLS(MAXC), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .in_bus  (in_if.slave),
        .out_bus (out_if.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_dvo"}, longint'(out_if.dv), 0);
        chk({name, "_dtypeo"}, longint'(out_if.dtype), 0);
        chk({name, "_meta"}, longint'(out_if.meta_data), 0);
        chk({name, "_yo"}, longint'(out_if.y), 0);
        chk({name, "_uo"}, longint'(out_if.u), 0);
        chk({name, "_vo"}, longint'(out_if.v), 0);
        chk({name, "_cvo"}, longint'(out_if.cv), 0);
    endtask

    task automatic drive_idle();
        in_if.dv        = 1'b0;
        in_if.dtype     = '0;
        in_if.meta_data = '0;
        in_if.y         = '0;
        in_if.u         = '0;
        in_if.v         = '0;
        in_if.cv        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            drive_idle();
        end
    endtask

    task automatic model_reset();
        m_mode = 1'b0;
        m_row  = 0;
        m_col  = 0;
        last_u = 0;
        last_v = 0;
    endtask

    // One input beat plus its predicted output two cycles later, then the configured gap.
    task automatic beat(input logic [2:0] dt, input int u, input int v, input int y);
        exp_t e;
        int   eu;
        int   ev;
        bit   cvv;
        @(posedge clk); #1;
        in_if.dv        = 1'b1;
        in_if.dtype     = dt;
        in_if.meta_data = DW'(meta_cnt);
        in_if.y         = PW'(y);
        in_if.u         = PW'(u);
        in_if.v         = PW'(v);
        cvv = 1'b0;
        eu  = last_u;
        ev  = last_v;
        if (dt == DT_FRAME_START) begin
            m_mode = enable;
            m_row  = 0;
            m_col  = 0;
        end
        if (dt == DT_ROW_START) m_col = 0;
        if (dt == DT_ROW_END) m_row++;
        if (dt == DT_PIXEL) begin
            if (m_col < 32) begin
                fu[m_row % 2][m_col] = u;
                fv[m_row % 2][m_col] = v;
            end
            if (m_mode && (m_row % 2 == 1) && (m_col % 2 == 1) && (m_col < int'(MAXC))) begin
                cvv = 1'b1;
                eu = (fu[0][m_col-1] + fu[0][m_col] + fu[1][m_col-1] + u + 2) / 4;
                ev = (fv[0][m_col-1] + fv[0][m_col] + fv[1][m_col-1] + v + 2) / 4;
                mdl_cv_u.push_back(eu);
                mdl_cv_v.push_back(ev);
            end
            m_col++;
        end
        if (!m_mode) begin
            eu = u;
            ev = v;
        end
        last_u = eu;
        last_v = ev;
        e.cyc   = cyc + 2;
        e.dtype = dt;
        e.meta  = DW'(meta_cnt);
        e.y     = PW'(y);
        e.u     = PW'(eu);
        e.v     = PW'(ev);
        e.cv    = cvv;
        exp_q.push_back(e);
        meta_cnt++;
        repeat (gap) begin
            @(posedge clk); #1;
            drive_idle();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive_idle();
        reset = 1'b1;
        #1;
        chk_zero_outputs("async_reset");
        exp_q.delete();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // pat 0: U=100+4c+2r, V=U+1; 1: rounding block; 2: all 1023; 3: random.
    task automatic frame(input int rows, input int cols, input int pat,
                         input int abort_r, input int abort_c, input bit toggle);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                case (pat)
                    0: begin pu[r][c] = 100 + 4*c + 2*r; pv[r][c] = pu[r][c] + 1; end
                    1: begin pu[r][c] = (r == 1 && c == 1) ? 2 : 1; pv[r][c] = pu[r][c]; end
                    2: begin pu[r][c] = 1023; pv[r][c] = 1023; end
                    default: begin
                        pu[r][c] = int'($urandom_range(0, 1023));
                        pv[r][c] = int'($urandom_range(0, 1023));
                    end
                endcase
            end
        end
        dut_cv_u.delete(); dut_cv_v.delete();
        mdl_cv_u.delete(); mdl_cv_v.delete();
        beat(DT_FRAME_START, 0, 0, 0);
        for (int r = 0; r < rows; r++) begin
            beat(DT_ROW_START, 0, 0, 0);
            for (int c = 0; c < cols; c++) begin
                if (r == abort_r && c == abort_c) begin
                    do_reset();
                    return;
                end
                beat(DT_PIXEL, pu[r][c], pv[r][c], (16*r + c + 5) % 1024);
            end
            beat(DT_ROW_END, 0, 0, 0);
            if (toggle && r == 0) enable = ~enable;
        end
        beat(DT_FRAME_END, 0, 0, 0);
        idle(4);
    endtask

    task automatic chk_first_frame(input string name);
        chk({name, "_cv_count"}, dut_cv_u.size(), 2);
        chk({name, "_model_cv_count"}, mdl_cv_u.size(), 2);
        if (dut_cv_u.size() == 2) begin
            chk({name, "_u_col1"}, dut_cv_u[0], 103);
            chk({name, "_v_col1"}, dut_cv_v[0], 104);
            chk({name, "_u_col3"}, dut_cv_u[1], 111);
            chk({name, "_v_col3"}, dut_cv_v[1], 112);
        end
        if (mdl_cv_u.size() == 2) begin
            chk({name, "_model_u_col1"}, mdl_cv_u[0], 103);
            chk({name, "_model_u_col3"}, mdl_cv_u[1], 111);
        end
    endtask

    // Output compare: every dvo beat against the reference, idle cycles must not flag cvo.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk_zero_outputs("in_reset");
                exp_q.delete();
            end else if (out_if.dv) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_dvo", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dvo_latency", cyc, e.cyc);
                    chk("dtypeo", longint'(out_if.dtype), longint'(e.dtype));
                    chk("meta_datao", longint'(out_if.meta_data), longint'(e.meta));
                    chk("yo", longint'(out_if.y), longint'(e.y));
                    chk("uo", longint'(out_if.u), longint'(e.u));
                    chk("vo", longint'(out_if.v), longint'(e.v));
                    chk("cvo", longint'(out_if.cv), longint'(e.cv));
                end
                if (out_if.cv) begin
                    dut_cv_u.push_back(int'(out_if.u));
                    dut_cv_v.push_back(int'(out_if.v));
                end
            end else begin
                chk("cvo_idle", longint'(out_if.cv), 0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    chk("missing_dvo", 0, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset_state");
        reset = 1'b0;
        idle(2);

        enable = 1'b1; gap = 0;
        frame(2, 4, 0, -1, -1, 1'b0);
        chk_first_frame("decimate");

        enable = 1'b0;
        frame(2, 4, 0, -1, -1, 1'b0);
        chk("passthru_cv_count", dut_cv_u.size(), 0);

        enable = 1'b1;
        frame(2, 2, 1, -1, -1, 1'b0);
        chk("round_cv_count", dut_cv_u.size(), 1);
        if (dut_cv_u.size() == 1) chk("round_u", dut_cv_u[0], 1);
        frame(2, 2, 2, -1, -1, 1'b0);
        chk("max_cv_count", dut_cv_u.size(), 1);
        if (dut_cv_u.size() == 1) chk("max_u", dut_cv_u[0], 1023);

        frame(2, 5, 3, -1, -1, 1'b0);
        chk("odd_width_cv_count", dut_cv_u.size(), 2);
        frame(3, 4, 3, -1, -1, 1'b0);
        chk("odd_height_cv_count", dut_cv_u.size(), 2);
        frame(2, 9, 3, -1, -1, 1'b0);
        chk("saturate_cv_count", dut_cv_u.size(), 3);
        frame(4, 6, 3, -1, -1, 1'b0);
        chk("random_cv_count", dut_cv_u.size(), 6);

        gap = 3;
        frame(2, 4, 0, -1, -1, 1'b0);
        chk_first_frame("gapped");
        gap = 0;

        frame(2, 4, 0, 1, 2, 1'b0);
        idle(2);
        frame(2, 4, 0, -1, -1, 1'b0);
        chk_first_frame("after_reset");

        enable = 1'b1;
        frame(2, 4, 0, -1, -1, 1'b1);
        chk("toggle_off_midframe_cv_count", dut_cv_u.size(), 2);
        enable = 1'b0;
        frame(2, 4, 0, -1, -1, 1'b1);
        chk("toggle_on_midframe_cv_count", dut_cv_u.size(), 0);
        frame(2, 4, 0, -1, -1, 1'b0);
        chk_first_frame("next_frame_enabled");

        idle(4);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
